// File: rtl/sram_to_sram_pkg.sv
// Shared definitions for the SRAM-to-SRAM read and write sides: default geometry,
// element/address/vector types and a width helper.
package sram_to_sram_pkg;

  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_UNIT_LEN  = 64;

  typedef logic        [DEF_ADDR_BITS-1:0] addr_t;
  typedef logic signed [DEF_DATA_BITS-1:0] data_t;
  typedef data_t       [DEF_UNIT_LEN-1:0]  vec_t;

  // Flattened width of one SRAM word.
  function automatic int vec_bits(input int unit_len, input int data_bits);
    return unit_len * data_bits;
  endfunction

endpackage

// File: rtl/sram_to_sram_write_if.sv
// Input beat stream plus SRAM write port of the write side. The producer uses the
// master modport, sram_to_sram_write uses the slave modport.
interface sram_to_sram_write_if
  import sram_to_sram_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int UNIT_LEN  = DEF_UNIT_LEN
);
  localparam int VEC_BITS = vec_bits(UNIT_LEN, DATA_BITS);

  logic [ADDR_BITS-1:0] s_addr;
  logic [VEC_BITS-1:0]  s_data;
  logic                 s_valid;
  logic                 mem_wen;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [VEC_BITS-1:0]  mem_wdata;

  modport master (
    output s_addr, s_data, s_valid,
    input  mem_wen, mem_waddr, mem_wdata
  );

  modport slave (
    input  s_addr, s_data, s_valid,
    output mem_wen, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/sram_to_sram_addr_checker.sv
// Address-order checker: each write must hit 0 when no frame is open, otherwise the
// previous write address + 1. Any violation sets a sticky error until reset.
module sram_to_sram_addr_checker #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_cke,
  input  logic                 i_wen,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic                 i_busy,
  output logic                 o_err
);
  logic [ADDR_BITS-1:0] r_prev;
  logic                 r_err;
  logic [ADDR_BITS-1:0] w_expected;

  assign w_expected = i_busy ? r_prev + ADDR_BITS'(1) : '0;

  // r_prev is only consulted while a frame is open, which needs a prior write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (i_cke && i_wen) begin
      r_prev <= i_waddr;
      if (i_waddr != w_expected) r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
endmodule

// File: rtl/sram_to_sram_write.sv
// Write side of the SRAM-to-SRAM pipeline: two register stages from the beat stream to
// the SRAM write port, plus frame tracking (busy/done/wcount). The address-order checker
// is built only when SRAM_TO_SRAM_WRITE_CHECK_EN is defined; otherwise err is tied low.
module sram_to_sram_write
  import sram_to_sram_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int UNIT_LEN  = DEF_UNIT_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_cke,
  sram_to_sram_write_if.slave    bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ADDR_BITS:0]     o_wcount,
  output logic                   o_err
);
  localparam int VEC_BITS = vec_bits(UNIT_LEN, DATA_BITS);
  localparam logic [ADDR_BITS:0] WCOUNT_MAX = {1'b1, {ADDR_BITS{1'b0}}};

  typedef struct packed {
    logic                 valid;
    logic [ADDR_BITS-1:0] addr;
    logic [VEC_BITS-1:0]  data;
  } beat_t;

  beat_t              r_st0;
  beat_t              r_st1;
  logic               r_busy;
  logic               r_done;
  logic [ADDR_BITS:0] r_wcount;

  logic w_wr;
  logic w_first;
  logic w_last;

  // NOTE: only the valid bits are reset; addr/data are qualified by valid, so leaving
  // the wide datapath without reset is safe and keeps it out of the reset tree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st0.valid <= 1'b0;
      r_st1.valid <= 1'b0;
    end else if (i_cke) begin
      r_st0 <= '{valid: bus.s_valid, addr: bus.s_addr, data: bus.s_data};
      r_st1 <= r_st0;
    end
  end

  // A stalled stage must not re-issue its write, so the enable is qualified by cke.
  assign w_wr    = r_st1.valid & i_cke;
  assign w_first = w_wr && (r_st1.addr == '0);
  assign w_last  = w_wr && (r_st1.addr == '1);

  assign bus.mem_wen   = w_wr;
  assign bus.mem_waddr = r_st1.addr;
  assign bus.mem_wdata = r_st1.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wcount <= '0;
    end else begin
      r_done <= w_last;
      if (w_first) begin
        r_busy   <= 1'b1;
        r_wcount <= (ADDR_BITS+1)'(1);
      end else if (w_wr) begin
        if (w_last) r_busy <= 1'b0;
        if (r_wcount != WCOUNT_MAX) r_wcount <= r_wcount + (ADDR_BITS+1)'(1);
      end
    end
  end

  // A frame start in the cycle the previous frame closes keeps busy high without a dip.
  assign o_busy   = r_busy | w_first;
  assign o_done   = r_done;
  assign o_wcount = r_wcount;

`ifdef SRAM_TO_SRAM_WRITE_CHECK_EN
  sram_to_sram_addr_checker #(
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_checker (
    .clk     (clk),
    .reset   (reset),
    .i_cke   (i_cke),
    .i_wen   (w_wr),
    .i_waddr (r_st1.addr),
    .i_busy  (r_busy),
    .o_err   (o_err)
  );
`else
  assign o_err = 1'b0;
`endif

endmodule
